// File: rtl/ft8_symbol_demapper_if.sv
// Symbol stream in, recovered FT8 codeword out.
interface ft8_symbol_demapper_if;
  logic [2:0]   symbol_in;
  logic         symbol_in_valid;
  logic         frame_start;
  logic [173:0] codeword;
  logic         codeword_valid;
  logic         sync_fail;
  logic [6:0]   sync_err_count;

  modport master (
    output symbol_in, symbol_in_valid, frame_start,
    input  codeword, codeword_valid, sync_fail, sync_err_count
  );

  modport slave (
    input  symbol_in, symbol_in_valid, frame_start,
    output codeword, codeword_valid, sync_fail, sync_err_count
  );
endinterface

// File: rtl/ft8_symbol_demapper.sv
// FT8 79-symbol frame demapper: strips Costas sync blocks, Gray-decodes 58 data tones into 174 bits.
// Define FT8_DEMAP_SYNC_CHECK_EN to count Costas mismatches and drive sync_fail.
module ft8_symbol_demapper #(
  parameter int SYNC_ERR_MAX = 3
) (
  input logic clk,
  input logic rst_n,
  ft8_symbol_demapper_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SYNC, DATA, DONE} state_t;

  localparam logic [6:0] ERR_MAX = 7'(SYNC_ERR_MAX);

  state_t       state_reg;
  logic [6:0]   idx_reg;
  logic [173:0] asm_reg;
  logic [173:0] codeword_reg;
  logic         valid_reg;
  logic         fail_reg;
  logic [6:0]   err_reg;

  logic [6:0]   pos;
  logic         is_data;
  logic [2:0]   gray_bits;
  logic [173:0] asm_base;
  logic [173:0] asm_next;
  logic [6:0]   err_next;
  logic         fail_next;

  // Index of the symbol presented this cycle; frame_start forces it to the frame origin.
  assign pos     = bus.frame_start ? 7'd0 : idx_reg;
  assign is_data = ((pos >= 7'd7) && (pos <= 7'd35)) || ((pos >= 7'd43) && (pos <= 7'd71));

  always_comb begin
    gray_bits = 3'd0;
    case (bus.symbol_in)
      3'd0:    gray_bits = 3'd0;
      3'd1:    gray_bits = 3'd1;
      3'd2:    gray_bits = 3'd3;
      3'd3:    gray_bits = 3'd2;
      3'd4:    gray_bits = 3'd6;
      3'd5:    gray_bits = 3'd4;
      3'd6:    gray_bits = 3'd5;
      default: gray_bits = 3'd7;
    endcase
  end

  assign asm_base = (pos == 7'd0) ? '0 : asm_reg;
  assign asm_next = is_data ? {asm_base[170:0], gray_bits} : asm_base;

`ifdef FT8_DEMAP_SYNC_CHECK_EN
  logic [2:0] sync_off;
  logic [2:0] costas_tone;
  logic       mismatch;
  logic [6:0] err_base;

  always_comb begin
    sync_off = 3'd0;
    if (pos < 7'd7)
      sync_off = 3'(pos);
    else if (pos < 7'd43)
      sync_off = 3'(pos - 7'd36);
    else
      sync_off = 3'(pos - 7'd72);

    costas_tone = 3'd2;
    case (sync_off)
      3'd0:    costas_tone = 3'd3;
      3'd1:    costas_tone = 3'd1;
      3'd2:    costas_tone = 3'd4;
      3'd3:    costas_tone = 3'd0;
      3'd4:    costas_tone = 3'd6;
      3'd5:    costas_tone = 3'd5;
      default: costas_tone = 3'd2;
    endcase

    mismatch = !is_data && (bus.symbol_in != costas_tone);
    err_base = (pos == 7'd0) ? 7'd0 : err_reg;
    err_next = (mismatch && (err_base < 7'd21)) ? err_base + 7'd1 : err_base;
  end
`else
  assign err_next = 7'd0;
`endif

  assign fail_next = (err_next > ERR_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      idx_reg      <= 7'd0;
      asm_reg      <= '0;
      codeword_reg <= '0;
      valid_reg    <= 1'b0;
      fail_reg     <= 1'b0;
      err_reg      <= 7'd0;
    end else begin
      valid_reg <= 1'b0;
      if (bus.frame_start && !bus.symbol_in_valid) begin
        state_reg <= IDLE;
        idx_reg   <= 7'd0;
        asm_reg   <= '0;
        err_reg   <= 7'd0;
      end else if (bus.symbol_in_valid) begin
        asm_reg <= asm_next;
        err_reg <= err_next;
        if (pos == 7'd78) begin
          // Last Costas symbol: publish the frame in the DONE cycle.
          state_reg    <= DONE;
          idx_reg      <= 7'd0;
          codeword_reg <= asm_next;
          valid_reg    <= 1'b1;
          fail_reg     <= fail_next;
        end else begin
          idx_reg <= pos + 7'd1;
          if (bus.frame_start) begin
            state_reg <= SYNC;
          end else begin
            case (state_reg)
              IDLE, DONE: state_reg <= SYNC;
              SYNC:       state_reg <= ((pos == 7'd6) || (pos == 7'd42)) ? DATA : SYNC;
              DATA:       state_reg <= ((pos == 7'd35) || (pos == 7'd71)) ? SYNC : DATA;
              default:    state_reg <= IDLE;
            endcase
          end
        end
      end else if (state_reg == DONE) begin
        state_reg <= IDLE;
      end
    end
  end

  assign bus.codeword       = codeword_reg;
  assign bus.codeword_valid = valid_reg;
  assign bus.sync_fail      = fail_reg;
  assign bus.sync_err_count = err_reg;

endmodule

// File: doc/ft8_symbol_demapper.md
FT8_SYMBOL_DEMAPPER -- requirements
Module: ft8_symbol_demapper

Interface
REQ-001 Parameter SYNC_ERR_MAX, default 3, max Costas-symbol mismatches per frame tolerated before sync_fail.
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 symbol_in  input  3  received hard-decision tone index 0..7.
REQ-005 symbol_in_valid  input  1  symbol_in accepted on any cycle this is high; gaps of any length allowed.
REQ-006 frame_start  input  1  single-cycle pulse, forces symbol index to 0.
REQ-007 codeword  output  174  recovered LDPC codeword, bit 173 first-transmitted.
REQ-008 codeword_valid  output  1  one-cycle pulse, codeword complete.
REQ-009 sync_fail  output  1  qualifies codeword_valid; high when Costas mismatches exceeded SYNC_ERR_MAX.
REQ-010 sync_err_count  output  7  Costas mismatches in current/last frame.

Function
REQ-011 Frame = 79 symbols, index 0..78, counted by a 7-bit symbol counter advanced once per accepted symbol.
REQ-012 Sync positions 0-6, 36-42, 72-78; expected tones per block 3,1,4,0,6,5,2.
REQ-013 Data positions 7-35 and 43-71 (58 symbols); each yields 3 bits via inverse Gray map tone->bits: 0->0,1->1,2->3,3->2,4->6,5->4,6->5,7->7.
REQ-014 Data bits shift into a 174-bit assembly register MSB-first: data symbol k (0..57) fills codeword[173-3k : 171-3k].
REQ-015 States: IDLE (waiting first symbol), SYNC (in Costas block), DATA (in data block), DONE (one cycle, output update).
REQ-016 IDLE->SYNC on first accepted symbol; SYNC->DATA after index 6 or 42; DATA->SYNC after index 35 or 71; SYNC->DONE after index 78; DONE->IDLE unconditionally.
REQ-017 In DONE: codeword loaded from assembly register, codeword_valid=1 for exactly one cycle, sync_fail updated; latency = one cycle after the cycle accepting symbol 78.
REQ-018 codeword and sync_fail hold their values until next DONE.
REQ-019 symbol_in_valid high during DONE: symbol accepted as index 0 of next frame (no symbol dropped, back-to-back frames supported).
REQ-020 frame_start alone: counter, assembly register and mismatch count cleared, state IDLE, no codeword_valid.
REQ-021 frame_start with symbol_in_valid same cycle: clear, then that symbol taken as index 0.
REQ-022 frame_start mid-frame aborts frame; codeword_valid never asserted for the aborted frame.
REQ-023 sync_err_count saturates at 21; cleared at frame start (index 0 accepted or frame_start).
REQ-024 Counter never exceeds 78; no wrap without DONE.

Reset
REQ-025 rst_n low: state IDLE, counter 0, assembly register 0, codeword 0, codeword_valid 0, sync_fail 0, sync_err_count 0, immediately and asynchronously.
REQ-026 Reset mid-frame discards partial frame; first symbol after release is index 0.

Configuration
REQ-027 Macro FT8_DEMAP_SYNC_CHECK_EN defined: each sync-position symbol compared to expected Costas tone, mismatches counted, sync_fail = (count > SYNC_ERR_MAX) at DONE.
REQ-028 Macro undefined: sync symbols consumed and discarded, no comparator logic, sync_err_count tied 0, sync_fail tied 0; all other timing identical.

Verification
REQ-029 Correct Costas + all data tones 0, contiguous valid -> codeword=0, codeword_valid one cycle after symbol 78, sync_fail=0.
REQ-030 First data symbol tone 4, rest 0 -> codeword[173:171]=3'b110, all other bits 0; last data symbol tone 2 -> codeword[2:0]=3'b011.
REQ-031 (SYNC_CHECK_EN, SYNC_ERR_MAX=3) 4 Costas tones corrupted -> sync_err_count=4, sync_fail=1; 3 corrupted -> sync_fail=0.
REQ-032 frame_start at symbol 40, then 79 clean symbols with random gaps -> exactly one codeword_valid, codeword matches second frame.
REQ-033 Two frames back-to-back with symbol_in_valid held high -> two codeword_valid pulses 79 cycles apart, both codewords correct.
REQ-034 rst_n low at symbol 50, release, send full frame -> single correct codeword_valid, no pulse from partial frame.
